// File: rtl/fetch_buffered_pkg.sv
// Shared defaults for the light RV32I fetch path.
package fetch_buffered_pkg;
  localparam int unsigned XLEN_DEF     = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  // Decode inserts this when it needs a bubble.
  localparam logic [31:0] INSTR_NOP    = 32'h0000_0013;
endpackage

// File: rtl/fetch_buffered_sync_fifo.sv
// Synchronous FIFO with flush; pointers and count reset, storage does not.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign do_push = push && !flush;
  assign do_pop  = pop && !flush && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
endmodule

// File: rtl/fetch_buffered.sv
// Buffered fetch stage: sequential PC generation, credit-limited imem requests,
// prefetch FIFO toward decode, and redirect flush with in-flight response dropping.
module fetch_buffered
  import fetch_buffered_pkg::*;
#(
  parameter int              XLEN            = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC        = XLEN'(RESET_PC_DEF),
  parameter int              FIFO_DEPTH      = 4,
  parameter int              MAX_OUTSTANDING = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic            o_imem_req_valid,
  output logic [XLEN-1:0] o_imem_req_addr,
  input  logic            i_imem_req_ready,
  input  logic            i_imem_resp_valid,
  input  logic [31:0]     i_imem_resp_data,
  output logic            o_valid,
  output logic [XLEN-1:0] o_pc,
  output logic [31:0]     o_instr,
  input  logic            i_ready
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d, redirect_tgt;
  logic [CW-1:0]   outstanding_q, outstanding_d, drop_cnt_q, drop_cnt_d;
  logic [CW-1:0]   fifo_count;
  logic [CW:0]     credits_used;
  logic            fifo_full, fifo_empty, req_fire, resp_drop, fifo_push, fifo_pop;
  logic [XLEN+31:0] fifo_rdata;
  logic            unused_pc_lsb;

  assign redirect_tgt  = {i_redirect_pc[XLEN-1:2], 2'b00};
  assign unused_pc_lsb = ^i_redirect_pc[1:0];

  // Every in-flight request owns a FIFO slot, so a response always has room.
  assign credits_used     = {1'b0, outstanding_q} + {1'b0, fifo_count};
  assign o_imem_req_valid = !reset && !i_redirect
                            && (outstanding_q < CW'(MAX_OUTSTANDING))
                            && (credits_used < (CW+1)'(FIFO_DEPTH));
  assign o_imem_req_addr  = fetch_pc_q;
  assign req_fire         = o_imem_req_valid && i_imem_req_ready;

  assign resp_drop = (drop_cnt_q != '0);
  assign fifo_push = i_imem_resp_valid && !resp_drop && !i_redirect;
  assign o_valid   = !fifo_empty && !i_redirect;
  assign fifo_pop  = o_valid && i_ready;
  assign o_pc      = fifo_empty ? '0 : fifo_rdata[XLEN+31:32];
  assign o_instr   = fifo_empty ? '0 : fifo_rdata[31:0];

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q;
    drop_cnt_d    = drop_cnt_q;
    if (i_redirect) begin
      fetch_pc_d    = redirect_tgt;
      resp_pc_d     = redirect_tgt;
      outstanding_d = outstanding_q - CW'(i_imem_resp_valid);
      drop_cnt_d    = outstanding_q - CW'(i_imem_resp_valid);
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(4);
      outstanding_d = outstanding_q + CW'(req_fire) - CW'(i_imem_resp_valid);
      if (i_imem_resp_valid) begin
        if (resp_drop) drop_cnt_d = drop_cnt_q - CW'(1);
        else           resp_pc_d  = resp_pc_q + XLEN'(4);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  sync_fifo #(.WIDTH(XLEN + 32), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (i_redirect),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata ({resp_pc_q, i_imem_resp_data}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  a_no_overflow: assert property (@(posedge clk) disable iff (reset) fifo_push |-> !fifo_full);
  a_resp_expected: assert property (@(posedge clk) disable iff (reset)
                                    i_imem_resp_valid |-> (outstanding_q != '0));
endmodule

// File: tb/tb_fetch_buffered.sv
// Bench for fetch_buffered: in-order variable-latency imem model plus a stream model of decode.
module tb_fetch_buffered;
  localparam int MAXO = 2;

  logic        clk, reset, i_redirect, i_imem_req_ready, i_imem_resp_valid, i_ready;
  logic [31:0] i_redirect_pc, i_imem_resp_data, o_imem_req_addr, o_pc, o_instr;
  logic        o_imem_req_valid, o_valid;

  fetch_buffered dut (
    .clk(clk), .reset(reset), .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
    .o_imem_req_valid(o_imem_req_valid), .o_imem_req_addr(o_imem_req_addr),
    .i_imem_req_ready(i_imem_req_ready), .i_imem_resp_valid(i_imem_resp_valid),
    .i_imem_resp_data(i_imem_resp_data), .o_valid(o_valid), .o_pc(o_pc),
    .o_instr(o_instr), .i_ready(i_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; } req_t;
  req_t        memq[$];
  logic [31:0] req_log[$];
  logic [31:0] pop_log[$];
  logic [31:0] exp_pc, exp_req;
  int checks = 0, failures = 0;
  int cyc = 0, lat = 1, out_cnt = 0, max_out = 0, first_acc = -1, first_valid = -1;
  logic redir_resp;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h0BAD_0013;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Compare process: sampled on the falling edge, inputs are stable by then.
  always @(negedge clk) begin
    logic acc;
    acc = 1'b0;
    if (reset) begin
      chk("rst_o_valid", o_valid, 0);
      chk("rst_req_valid", o_imem_req_valid, 0);
      chk("rst_o_pc", o_pc, 0);
      chk("rst_o_instr", o_instr, 0);
      out_cnt = 0;
      exp_pc  = 32'h0;
      exp_req = 32'h0;
    end else begin
      if (i_redirect) begin
        chk("redir_o_valid", o_valid, 0);
        chk("redir_req_valid", o_imem_req_valid, 0);
        redir_resp = i_imem_resp_valid;
        exp_pc  = {i_redirect_pc[31:2], 2'b00};
        exp_req = {i_redirect_pc[31:2], 2'b00};
        req_log.delete();
        pop_log.delete();
      end else begin
        chk("outstanding_le_max", (out_cnt <= MAXO), 1);
        if (out_cnt == MAXO) chk("req_blocked_at_max", o_imem_req_valid, 0);
        if (o_imem_req_valid && i_imem_req_ready) begin
          acc = 1'b1;
          chk("req_addr", o_imem_req_addr, exp_req);
          memq.push_back('{addr: o_imem_req_addr, due: cyc + lat});
          req_log.push_back(o_imem_req_addr);
          exp_req = exp_req + 32'd4;
          if (first_acc < 0) first_acc = cyc;
        end
        if (o_valid && i_ready) begin
          chk("pop_pc", o_pc, exp_pc);
          chk("pop_instr", o_instr, instr_of(exp_pc));
          pop_log.push_back(o_pc);
          exp_pc = exp_pc + 32'd4;
          if (first_valid < 0) first_valid = cyc;
        end
      end
      out_cnt = out_cnt + (acc ? 1 : 0) - (i_imem_resp_valid ? 1 : 0);
      if (out_cnt > max_out) max_out = out_cnt;
    end
  end

  task automatic tick();
    i_imem_resp_valid = 1'b0;
    i_imem_resp_data  = 32'h0;
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      i_imem_resp_valid = 1'b1;
      i_imem_resp_data  = instr_of(memq[0].addr);
      void'(memq.pop_front());
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_log();
    req_log.delete();
    pop_log.delete();
    first_acc = -1;
    first_valid = -1;
    max_out = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    i_redirect = 1'b0;
    i_imem_resp_valid = 1'b0;
    memq.delete();
    tick();
    tick();
    reset = 1'b0;
    clear_log();
  endtask

  task automatic redirect(input logic [31:0] pc);
    i_redirect = 1'b1;
    i_redirect_pc = pc;
    tick();
    i_redirect = 1'b0;
  endtask

  task automatic run_until_pops(input int n);
    for (int k = 0; k < 200 && pop_log.size() < n; k++) tick();
    chk("pop_budget", (pop_log.size() >= n), 1);
  endtask

  initial begin
    reset = 1'b1; i_redirect = 1'b0; i_redirect_pc = 32'h0; i_imem_req_ready = 1'b1;
    i_imem_resp_valid = 1'b0; i_imem_resp_data = 32'h0; i_ready = 1'b1;

    // Reset values held without a release
    lat = 1;
    tick(); tick();
    chk("rst_req_addr", o_imem_req_addr, 32'h0);

    // Streaming, 1-cycle imem
    do_reset();
    for (int k = 0; k < 10; k++) tick();
    chk("t1_first_latency", first_valid - first_acc, 2);
    chk("t1_first_pc", pop_log[0], 32'h0);
    chk("t1_pop_count", pop_log.size(), 8);

    // Decode stalled: exactly FIFO_DEPTH entries fetched
    i_ready = 1'b0;
    do_reset();
    for (int k = 0; k < 12; k++) tick();
    chk("t2_accepts", req_log.size(), 4);
    chk("t2_req_valid_low", o_imem_req_valid, 0);
    i_ready = 1'b1;
    run_until_pops(5);
    chk("t2_pop0", pop_log[0], 32'h0);
    chk("t2_pop3", pop_log[3], 32'hC);
    chk("t2_pop4", pop_log[4], 32'h10);

    // 3-cycle imem: in-flight limited to MAX_OUTSTANDING
    lat = 3;
    do_reset();
    for (int k = 0; k < 30; k++) tick();
    chk("t3_max_out", max_out, 2);

    // Redirect with 2 in flight and 2 buffered
    i_ready = 1'b0;
    do_reset();
    for (int k = 0; k < 50 && !(req_log.size() == 4 && out_cnt == 2); k++) tick();
    chk("t4_setup_out", out_cnt, 2);
    redirect(32'h100);
    chk("t4_flushed", o_valid, 0);
    i_ready = 1'b1;
    run_until_pops(3);
    chk("t4_pop0", pop_log[0], 32'h100);
    chk("t4_pop1", pop_log[1], 32'h104);

    // Redirect on top of a response and a pop; unaligned target
    lat = 1;
    do_reset();
    for (int k = 0; k < 6; k++) tick();
    redirect(32'h103);
    chk("t5_resp_same_cycle", redir_resp, 1);
    run_until_pops(3);
    chk("t5_req0", req_log[0], 32'h100);
    chk("t5_pop0", pop_log[0], 32'h100);
    chk("t5_pop2", pop_log[2], 32'h108);

    // Address wrap
    redirect(32'hFFFF_FFFC);
    run_until_pops(2);
    chk("t6_req1_wrap", req_log[1], 32'h0);
    chk("t6_pop0", pop_log[0], 32'hFFFF_FFFC);
    chk("t6_pop1", pop_log[1], 32'h0);

    // Asynchronous reset mid-burst
    for (int k = 0; k < 3; k++) tick();
    reset = 1'b1;
    i_imem_resp_valid = 1'b0;
    memq.delete();
    #1;
    chk("t7_o_valid", o_valid, 0);
    chk("t7_req_valid", o_imem_req_valid, 0);
    chk("t7_o_pc", o_pc, 0);
    chk("t7_o_instr", o_instr, 0);
    chk("t7_req_addr", o_imem_req_addr, 32'h0);
    do_reset();
    run_until_pops(2);
    chk("t7_restart_pc", pop_log[0], 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
